// File: rtl/seq_arith_responder.sv
// seq_arith_responder
//   Responder for the enable/operand/mode -> result/done operation handshake.
//   A request is accepted on a rising enable while idle; operands and mode are
//   latched, the result is produced either in one cycle (ADD/SUB/AND/XOR/ROL and
//   divide-by-zero) or bit-serially over WIDTH steps (MUL/DIV/REM), then done
//   pulses for one cycle and result holds until the next request completes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any request in flight
//   enable     request strobe; a held-high enable counts as one request
//   operand_1  dividend / multiplicand / rotate source
//   operand_2  divisor / multiplier / rotate amount
//   mode       0 ADD, 1 SUB, 2 AND, 3 XOR, 4 MUL, 5 DIV, 6 REM, 7 ROL
//   result     answer; changes only on the completion edge
//   done       one-cycle completion pulse
//   busy       high from the accept edge through the done cycle
module seq_arith_responder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] ModeAdd = 3'd0;
  localparam logic [2:0] ModeSub = 3'd1;
  localparam logic [2:0] ModeAnd = 3'd2;
  localparam logic [2:0] ModeXor = 3'd3;
  localparam logic [2:0] ModeMul = 3'd4;
  localparam logic [2:0] ModeDiv = 3'd5;
  localparam logic [2:0] ModeRem = 3'd6;
  localparam logic [2:0] ModeRol = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  // a_q: multiplicand (shifts left) or dividend/quotient (shifts left).
  // b_q: multiplier (shifts right) or divisor (constant).
  // acc_q: product accumulator or partial remainder.
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              en_q;

  logic              accept;
  logic              div_by_zero;
  logic              multi_cycle;
  logic [WIDTH-1:0]  alu_res;
  logic [2*WIDTH-1:0] rol_dbl;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    diff;

  assign accept = enable & ~en_q;

  always_comb begin
    div_by_zero = ((mode_q == ModeDiv) || (mode_q == ModeRem)) && (b_q == '0);
    multi_cycle = ((mode_q == ModeMul) || (mode_q == ModeDiv) || (mode_q == ModeRem)) &&
                  !div_by_zero;

    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    rol_dbl = {a_q, a_q} << b_q[ShW-1:0];

    // Restoring division step: shift next dividend bit into the remainder and
    // try subtracting the divisor; diff[WIDTH] set means the trial borrowed.
    trial = {acc_q, a_q[WIDTH-1]};
    diff  = trial - {1'b0, b_q};

    case (mode_q)
      ModeAdd: alu_res = a_q + b_q;
      ModeSub: alu_res = a_q - b_q;
      ModeAnd: alu_res = a_q & b_q;
      ModeXor: alu_res = a_q ^ b_q;
      ModeDiv: alu_res = '1;
      ModeRem: alu_res = a_q;
      ModeRol: alu_res = rol_dbl[2*WIDTH-1:WIDTH];
      default: alu_res = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = operand_1;
          b_d     = operand_2;
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (!multi_cycle) begin
          result_d = alu_res;
          state_d  = StFin;
        end else if (cnt_q == CntW'(WIDTH)) begin
          result_d = (mode_q == ModeDiv) ? a_q : acc_q;
          state_d  = StFin;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (mode_q == ModeMul) begin
            if (b_q[0]) begin
              acc_d = acc_q + a_q;
            end
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end else begin
            a_d   = {a_q[WIDTH-2:0], ~diff[WIDTH]};
            acc_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      en_q     <= enable;
    end
  end

  assign result = result_q;
  assign done   = (state_q == StFin);
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_seq_arith_responder.sv
module tb_seq_arith_responder;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic [2:0]   mode;
  logic [W-1:0] result;
  logic         done;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] sb[$];

  seq_arith_responder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .mode      (mode),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] m);
    logic [W-1:0] r;
    int s;
    s = int'(b[5:0]);
    case (m)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a * b;
      3'd5: r = (b == 0) ? {W{1'b1}} : a / b;
      3'd6: r = (b == 0) ? a : a % b;
      default: r = (s == 0) ? a : ((a << s) | (a >> (W - s)));
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b, input logic [2:0] m);
    if (m == 3'd4) return W + 1;
    if ((m == 3'd5 || m == 3'd6) && b != 0) return W + 1;
    return 1;
  endfunction

  // Issue one request, wait for done (bounded), compare result and latency,
  // then check the FIN cycle. mid_en re-pulses enable with junk operands mid-run.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] m, input bit mid_en);
    logic [W-1:0] prev;
    logic [W-1:0] exp;
    bit got;
    bit held;
    int n;
    sb.push_back(model(a, b, m));
    prev = result;
    @(negedge clk);
    operand_1 = a;
    operand_2 = b;
    mode      = m;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    check({tag, "_busy_accept"}, busy, 1);
    n = 0;
    got = 0;
    held = 1;
    while (n < 200 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (done) begin
        got = 1;
      end else begin
        if (result !== prev) held = 0;
        if (mid_en && n == 10) begin
          enable    = 1'b1;
          operand_1 = 64'hDEAD_BEEF_0BAD_F00D;
          operand_2 = 64'h5;
          mode      = 3'd0;
        end
        if (n == 12) enable = 1'b0;
      end
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_hold_during_calc"}, held, 1);
    if (got) begin
      exp = sb.pop_front();
      check({tag, "_result"}, result, exp);
      check({tag, "_latency"}, n, exp_latency(b, m));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_result_hold"}, result, exp);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   m;
    bit saw_done;

    rst = 1'b1;
    enable = 1'b1;
    operand_1 = 64'h1234;
    operand_2 = 64'h1;
    mode = 3'd0;

    // Reset for two cycles with enable high; enable must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    check("reset_result", result, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    check("post_reset_idle", busy, 0);

    do_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd0, 0);
    do_op("sub_wrap", 64'h0, 64'h1, 3'd1, 0);
    do_op("mul", 64'h1_0000_0001, 64'h3, 3'd4, 1);
    @(posedge clk);
    #1;
    check("mul_no_reaccept", busy, 0);
    do_op("div", 64'd100, 64'd7, 3'd5, 0);
    do_op("rem", 64'd100, 64'd7, 3'd6, 0);
    do_op("div0", 64'h55AA, 64'h0, 3'd5, 0);
    do_op("rem0", 64'h55AA, 64'h0, 3'd6, 0);
    do_op("rol", 64'h8000_0000_0000_0001, 64'h41, 3'd7, 0);
    do_op("and", 64'hF0F0_1234_FFFF_0000, 64'h0FF0_FFFF_00FF_FFFF, 3'd2, 0);
    do_op("xor", 64'hAAAA_5555_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 0);

    // Reset at edge k+30 of a MUL aborts it without a done.
    @(negedge clk);
    operand_1 = 64'h7;
    operand_2 = 64'h9;
    mode = 3'd4;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    saw_done = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1;
    end
    check("abort_quiet", saw_done, 0);
    do_op("add_after_abort", 64'd2, 64'd3, 3'd0, 0);

    // Back-to-back random requests.
    for (int i = 0; i < 80; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(32, 63);
      if ((m == 3'd5 || m == 3'd6) && $urandom_range(0, 5) == 0) b = '0;
      do_op($sformatf("rand%0d", i), a, b, m, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
